// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage RISC-V core. Produces the
// per-stage enables and flushes for the F/D, D/E, E/M and M/W pipeline
// registers. It resolves three hazard classes:
//   - load-use hazards between Execute and Decode (one bubble),
//   - branch/jump redirects taken in Execute (two flushed slots),
//   - multi-cycle data-memory accesses (req/ready handshake plus watchdog).
//
// Optional feature macro: HAZARD_PERF_EN
//   When defined, adds the saturating performance counters StallCnt_o and
//   FlushCnt_o. When undefined, those ports and counters are absent and all
//   other behaviour is identical.
//
// Parameters:
//   DATA_WIDTH   width of the performance counters
//   WAIT_MAX     MEM_WAIT cycles tolerated before the sticky error (>= 1)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   Rs1D_i/Rs2D_i  source registers of the instruction in Decode
//   RdE_i          destination register of the instruction in Execute
//   ResultSrcE_i   result source in Execute (2'b01 = load)
//   PCSrcE_i       redirect select from Execute (non-zero = taken)
//   MemAccessM_i   instruction in Memory is a load or store
//   MemReady_i     data memory completes the access this cycle
//   MemReq_o       data memory request
//   Fen_o..Men_o   F/D, D/E, E/M, M/W register enables
//   Frst_o         flush F/D (bubble into Decode)
//   Drst_o         flush D/E (bubble into Execute)
//   Wbubble_o      M/W register loads a bubble (RegWrite cleared)
//   err_o          sticky memory-timeout error
//   StallCnt_o     (HAZARD_PERF_EN) cycles with Fen_o low outside reset
//   FlushCnt_o     (HAZARD_PERF_EN) cycles flushing for redirect or load-use
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            Rs1D_i,
  input  logic [4:0]            Rs2D_i,
  input  logic [4:0]            RdE_i,
  input  logic [1:0]            ResultSrcE_i,
  input  logic [1:0]            PCSrcE_i,
  input  logic                  MemAccessM_i,
  input  logic                  MemReady_i,
  output logic                  MemReq_o,
  output logic                  Fen_o,
  output logic                  Den_o,
  output logic                  Een_o,
  output logic                  Men_o,
  output logic                  Frst_o,
  output logic                  Drst_o,
  output logic                  Wbubble_o,
  output logic                  err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] StallCnt_o,
  output logic [DATA_WIDTH-1:0] FlushCnt_o
`endif
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_MAX);
  // Value held during the final tolerated MEM_WAIT cycle: the increment on
  // that edge would make the counter reach WAIT_MAX.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Hazard terms
  logic lu_hz;     // load-use between Execute and Decode
  logic rd_hz;     // redirect taken in Execute
  logic mw_hz;     // memory access not completing this cycle
  logic flush_ev;  // a flush is being issued for rd_hz or lu_hz

  assign lu_hz = (ResultSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                 ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign rd_hz = (PCSrcE_i != 2'b00);
  assign mw_hz = MemAccessM_i && !MemReady_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case/if tree leaves a value unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    MemReq_o   = 1'b0;
    Fen_o      = 1'b1;
    Den_o      = 1'b1;
    Een_o      = 1'b1;
    Men_o      = 1'b1;
    Frst_o     = 1'b0;
    Drst_o     = 1'b0;
    Wbubble_o  = 1'b0;
    flush_ev   = 1'b0;

    unique case (state_q)
      S_RUN: begin
        MemReq_o = MemAccessM_i;
        if (mw_hz) begin
          // Freeze the whole pipe; M/W takes a bubble so the stalled memory
          // instruction is not written back twice.
          Fen_o      = 1'b0;
          Den_o      = 1'b0;
          Een_o      = 1'b0;
          Men_o      = 1'b0;
          Wbubble_o  = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = '0;
        end else if (rd_hz) begin
          // Redirect wins over load-use: the dependent instruction in Decode
          // is flushed anyway.
          Frst_o   = 1'b1;
          Drst_o   = 1'b1;
          flush_ev = 1'b1;
        end else if (lu_hz) begin
          Fen_o    = 1'b0;
          Den_o    = 1'b0;
          Drst_o   = 1'b1;
          flush_ev = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        MemReq_o   = 1'b1;
        wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        if (MemReady_i) begin
          // E was frozen during the wait, so a redirect or load-use seen here
          // is the one that was pending; apply it now.
          state_d = S_RUN;
          if (rd_hz) begin
            Frst_o   = 1'b1;
            Drst_o   = 1'b1;
            flush_ev = 1'b1;
          end else if (lu_hz) begin
            Fen_o    = 1'b0;
            Den_o    = 1'b0;
            Drst_o   = 1'b1;
            flush_ev = 1'b1;
          end
        end else begin
          Fen_o     = 1'b0;
          Den_o     = 1'b0;
          Een_o     = 1'b0;
          Men_o     = 1'b0;
          Wbubble_o = 1'b1;
          if (wait_cnt_q == CNT_LAST) begin
            state_d = S_ERROR;
          end
        end
      end

      S_ERROR: begin
        Fen_o     = 1'b0;
        Den_o     = 1'b0;
        Een_o     = 1'b0;
        Men_o     = 1'b0;
        Wbubble_o = 1'b1;
      end

      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Reset overrides everything: flush both front registers, keep the pipe
    // clocking so the bubbles propagate, and drop any outstanding request.
    if (rst) begin
      MemReq_o  = 1'b0;
      Fen_o     = 1'b1;
      Den_o     = 1'b1;
      Een_o     = 1'b1;
      Men_o     = 1'b1;
      Frst_o    = 1'b1;
      Drst_o    = 1'b1;
      Wbubble_o = 1'b1;
      flush_ev  = 1'b0;
    end
  end

  assign err_o = (state_q == S_ERROR) && !rst;

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!Fen_o && !rst && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_ev && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule
